cc_flag_unit: RTL and testbench

- Sequential consumer of the 64-bit ALU result path (add/sub/and/xor). Derives condition codes, buffers them one cycle and commits them to the architectural CC register.
- Evaluates jXX/cmovXX conditions against the newest flags, forwarding a flag update that has not yet committed.
- Sits between the execute-stage ALU and the PC-select/writeback control of the SEQ processor.

---
 rtl/cc_flag_unit.sv | 133 +++++++++++++
 tb/tb_cc_flag_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_flag_unit.sv
// rtl/cc_flag_unit.sv - condition-code derivation, one-entry pending buffer, commit and jXX/cmovXX evaluation
// Optional carry flag and below/above-or-equal conditions enabled by CC_CARRY_EN.
module cc_flag_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic [3:0]       alu_fun,
    input  logic             set_cc,
    input  logic             stall,
    input  logic             cond_valid,
    input  logic [3:0]       cond_fun,
    output logic             cond_out,
    output logic             cond_out_valid,
    output logic             cond_err,
`ifdef CC_CARRY_EN
    output logic [3:0]       cc,
`else
    output logic [2:0]       cc,
`endif
    output logic             busy
);

`ifdef CC_CARRY_EN
    localparam int FW = 4;
`else
    localparam int FW = 3;
`endif
    // Flag vector layout: [0]=ZF [1]=SF [2]=OF [3]=CF
    localparam logic [FW-1:0] CC_RESET = FW'(1);

    logic [FW-1:0] pend_flags;
    logic [FW-1:0] new_flags;
    logic [FW-1:0] eval_flags;
    logic          pend_valid;
    logic          accept;
    logic          cond_hit;
    logic          cond_bad;
    logic          sa;
    logic          sb;
    logic          so;
    logic          lt;

    assign sa = alu_a[WIDTH-1];
    assign sb = alu_b[WIDTH-1];
    assign so = alu_out[WIDTH-1];

`ifdef CC_CARRY_EN
    logic [WIDTH:0] sum_wide;
    assign sum_wide = {1'b0, alu_b} + {1'b0, alu_a};
`else
    logic unused_bits;
    assign unused_bits = ^{alu_a[WIDTH-2:0], alu_b[WIDTH-2:0]};
`endif

    assign alu_ready = !stall;
    assign accept    = alu_valid && alu_ready && set_cc && (alu_fun <= 4'd3);
    assign busy      = pend_valid;

    always_comb begin
        new_flags    = '0;
        new_flags[0] = (alu_out == '0);
        new_flags[1] = so;
        case (alu_fun)
            4'd0:    new_flags[2] = (sa == sb) && (so != sb);
            4'd1:    new_flags[2] = (sa != sb) && (so != sb);
            default: ;
        endcase
`ifdef CC_CARRY_EN
        if (alu_fun == 4'd0)
            new_flags[3] = sum_wide[WIDTH];
        else if (alu_fun == 4'd1)
            new_flags[3] = (alu_b < alu_a);
`endif
    end

    // Conditions see an uncommitted update; a same-edge accept is not forwarded.
    assign eval_flags = pend_valid ? pend_flags : cc;
    assign lt         = eval_flags[1] ^ eval_flags[2];

    always_comb begin
        cond_hit = 1'b0;
        cond_bad = 1'b0;
        case (cond_fun)
            4'd0: cond_hit = 1'b1;
            4'd1: cond_hit = lt || eval_flags[0];
            4'd2: cond_hit = lt;
            4'd3: cond_hit = eval_flags[0];
            4'd4: cond_hit = !eval_flags[0];
            4'd5: cond_hit = !lt;
            4'd6: cond_hit = !lt && !eval_flags[0];
`ifdef CC_CARRY_EN
            4'd7: cond_hit = eval_flags[3];
            4'd8: cond_hit = !eval_flags[3];
`endif
            default: cond_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc         <= CC_RESET;
            pend_valid <= 1'b0;
            pend_flags <= '0;
        end else if (!stall) begin
            if (pend_valid)
                cc <= pend_flags;
            pend_valid <= accept;
            if (accept)
                pend_flags <= new_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cond_out       <= 1'b0;
            cond_err       <= 1'b0;
            cond_out_valid <= 1'b0;
        end else begin
            cond_out_valid <= cond_valid && !stall;
            if (cond_valid && !stall) begin
                cond_out <= cond_hit;
                cond_err <= cond_bad;
            end
        end
    end

endmodule

// File: tb/tb_cc_flag_unit.sv
// tb/tb_cc_flag_unit.sv - randomized and directed bench for cc_flag_unit against a behavioural flag model
module tb_cc_flag_unit;
    localparam int W = 64;
`ifdef CC_CARRY_EN
    localparam int FW = 4;
    localparam bit HAS_CF = 1'b1;
`else
    localparam int FW = 3;
    localparam bit HAS_CF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [W-1:0]  alu_a = '0;
    logic [W-1:0]  alu_b = '0;
    logic [W-1:0]  alu_out = '0;
    logic [3:0]    alu_fun = '0;
    logic          set_cc = 1'b0;
    logic          stall = 1'b0;
    logic          cond_valid = 1'b0;
    logic [3:0]    cond_fun = '0;
    logic          cond_out;
    logic          cond_out_valid;
    logic          cond_err;
    logic [FW-1:0] cc;
    logic          busy;

    cc_flag_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_fun(alu_fun),
        .set_cc(set_cc), .stall(stall), .cond_valid(cond_valid), .cond_fun(cond_fun),
        .cond_out(cond_out), .cond_out_valid(cond_out_valid), .cond_err(cond_err),
        .cc(cc), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model state, flags always held as {CF,OF,SF,ZF}
    logic [3:0] m_cc;
    logic [3:0] m_pend;
    bit         m_pv;
    bit         m_cov;
    bit         m_co;
    bit         m_ce;
    logic [FW-1:0] m_cc_view;

    function automatic logic [3:0] flags_of(input logic [3:0] fun, input logic [63:0] a,
                                            input logic [63:0] b, input logic [63:0] out);
        bit zf, sf, of, cf;
        logic [64:0] wide;
        zf = (out == 64'd0);
        sf = out[63];
        of = 1'b0;
        cf = 1'b0;
        if (fun == 4'd0) begin
            of   = (a[63] == b[63]) && (out[63] != b[63]);
            wide = {1'b0, b} + {1'b0, a};
            cf   = (wide > 65'h0_FFFF_FFFF_FFFF_FFFF);
        end else if (fun == 4'd1) begin
            of = (a[63] != b[63]) && (out[63] != b[63]);
            cf = (b < a);
        end
        if (!HAS_CF) cf = 1'b0;
        return {cf, of, sf, zf};
    endfunction

    // Returns {err, result}
    function automatic logic [1:0] cond_of(input logic [3:0] fun, input logic [3:0] f);
        bit zf, less, below;
        zf    = f[0];
        less  = f[1] ^ f[2];
        below = f[3];
        case (fun)
            4'd0: return 2'b01;
            4'd1: return {1'b0, less || zf};
            4'd2: return {1'b0, less};
            4'd3: return {1'b0, zf};
            4'd4: return {1'b0, !zf};
            4'd5: return {1'b0, !less};
            4'd6: return {1'b0, !less && !zf};
            4'd7: return HAS_CF ? {1'b0, below} : 2'b10;
            4'd8: return HAS_CF ? {1'b0, !below} : 2'b10;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            4: return 64'($urandom_range(0, 7));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [63:0] true_result(input logic [3:0] fun, input logic [63:0] a,
                                                input logic [63:0] b);
        case (fun)
            4'd0: return b + a;
            4'd1: return b - a;
            4'd2: return a & b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic model_reset();
        m_cc   = 4'b0001;
        m_pend = 4'b0000;
        m_pv   = 1'b0;
        m_cov  = 1'b0;
        m_co   = 1'b0;
        m_ce   = 1'b0;
    endtask

    // One clock: drive after negedge, advance model at posedge, compare at next negedge.
    task automatic cycle(input bit v, input logic [3:0] fun, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] out, input bit sc,
                         input bit st, input bit cv, input logic [3:0] cfn);
        logic [3:0] src;
        alu_valid = v; alu_fun = fun; alu_a = a; alu_b = b; alu_out = out;
        set_cc = sc; stall = st; cond_valid = cv; cond_fun = cfn;
        #1;
        check("alu_ready", alu_ready, !st);
        @(posedge clk);
        src = m_pv ? m_pend : m_cc;
        if (!st) begin
            m_cov = cv;
            if (cv) {m_ce, m_co} = cond_of(cfn, src);
            if (m_pv) m_cc = m_pend;
            if (v && sc && fun <= 4'd3) begin
                m_pend = flags_of(fun, a, b, out);
                m_pv   = 1'b1;
            end else begin
                m_pv = 1'b0;
            end
        end else begin
            m_cov = 1'b0;
        end
        @(negedge clk);
        m_cc_view = m_cc[FW-1:0];
        check("cc", cc, m_cc_view);
        check("busy", busy, m_pv);
        check("cond_out_valid", cond_out_valid, m_cov);
        if (m_cov) begin
            check("cond_out", cond_out, m_co);
            check("cond_err", cond_err, m_ce);
        end
    endtask

    task automatic idle(input bit cv, input logic [3:0] cfn);
        cycle(1'b0, 4'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, cv, cfn);
    endtask

    logic [3:0]  exp4;
    logic [FW-1:0] exp_cc;
    logic [FW-1:0] held_cc;
    logic [63:0] ra, rb, ro;
    logic [3:0]  rf;

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("reset_cc", cc, 64'd1);
        check("reset_busy", busy, 1'b0);
        check("reset_cov", cond_out_valid, 1'b0);
        check("reset_cond_out", cond_out, 1'b0);
        check("reset_cond_err", cond_err, 1'b0);

        // Sub producing zero
        cycle(1, 4'd1, 64'd5, 64'd5, 64'd0, 1, 0, 0, 4'd0);
        check("sub_busy", busy, 1'b1);
        idle(1, 4'd3);
        check("sub_busy_clear", busy, 1'b0);
        check("sub_cc", cc, 64'd1);
        check("sub_jz", cond_out, 1'b1);

        // Signed add overflow
        cycle(1, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 4'd0);
        idle(1, 4'd2);
        exp4 = 4'b0110; exp_cc = exp4[FW-1:0];
        check("ovf_cc", cc, exp_cc);
        check("ovf_jl", cond_out, 1'b0);
        idle(1, 4'd1);
        check("ovf_jle", cond_out, 1'b0);
        idle(1, 4'd5);
        check("ovf_jge", cond_out, 1'b1);

        // Forwarding of an uncommitted and-result of zero
        cycle(1, 4'd2, 64'hF0, 64'h0F, 64'd0, 1, 0, 0, 4'd0);
        check("fwd_busy", busy, 1'b1);
        check("fwd_old_zf", cc[0], 1'b0);
        idle(1, 4'd3);
        check("fwd_jz", cond_out, 1'b1);

        // Stall holds pending entry and cc
        cycle(1, 4'd0, 64'd1, 64'd2, 64'd3, 1, 0, 0, 4'd0);
        held_cc = cc;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 4'd0, 64'd0, 64'd0, 64'd0, 0, 1, 1, 4'd0);
            check("stall_cc", cc, held_cc);
            check("stall_cov", cond_out_valid, 1'b0);
        end
        idle(0, 4'd0);
        check("stall_commit", cc, 64'd0);

        // cond_fun 7 after sub 1-3: error without carry, CF=1 with it
        cycle(1, 4'd1, 64'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 4'd0);
        idle(1, 4'd7);
        check("c7_out", cond_out, HAS_CF);
        check("c7_err", cond_err, !HAS_CF);

        // Asynchronous reset mid-cycle with a pending entry
        cycle(1, 4'd3, 64'd6, 64'd3, 64'd5, 1, 0, 1, 4'd0);
        #2 rst_n = 1'b0;
        #1;
        check("areset_cc", cc, 64'd1);
        check("areset_busy", busy, 1'b0);
        check("areset_cov", cond_out_valid, 1'b0);
        model_reset();
        alu_valid = 1'b0; cond_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle(0, 4'd0);
        check("areset_no_commit", cc, 64'd1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            ra = rand64();
            rb = ($urandom_range(0, 7) == 0) ? ra : rand64();
            rf = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            ro = ($urandom_range(0, 3) == 0) ? rand64() : true_result(rf, ra, rb);
            cycle($urandom_range(0, 3) != 0, rf, ra, rb, ro, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
